// File: rtl/enemy_bullet_if.sv
// enemy_bullet_if: launch handshake, player-position inputs and bullet status/draw outputs
// for one enemy projectile. The slave modport is the bullet itself; the master modport is
// the game logic that fires it and consumes its hit/miss pulses.
interface enemy_bullet_if;
    // Game logic -> bullet
    logic       frame_tick_i;
    logic       fire_i;
    logic [9:0] fire_x_i;
    logic [9:0] fire_y_i;
    logic       freeze_i;
    logic       player_alive_i;
    logic [9:0] player_left_i;
    logic [9:0] player_right_i;
    // Bullet -> game logic / renderer
    logic       fire_ready_o;
    logic       active_o;
    logic [9:0] bullet_x_o;
    logic [9:0] bullet_y_o;
    logic       hit_o;
    logic       miss_o;
    logic [3:0] bullet_red_o;
    logic [3:0] bullet_green_o;
    logic [3:0] bullet_blue_o;
    logic [1:0] state_o;

    modport master (
        output frame_tick_i, fire_i, fire_x_i, fire_y_i, freeze_i,
               player_alive_i, player_left_i, player_right_i,
        input  fire_ready_o, active_o, bullet_x_o, bullet_y_o, hit_o, miss_o,
               bullet_red_o, bullet_green_o, bullet_blue_o, state_o
    );

    modport slave (
        input  frame_tick_i, fire_i, fire_x_i, fire_y_i, freeze_i,
               player_alive_i, player_left_i, player_right_i,
        output fire_ready_o, active_o, bullet_x_o, bullet_y_o, hit_o, miss_o,
               bullet_red_o, bullet_green_o, bullet_blue_o, state_o
    );
endinterface

// File: rtl/enemy_bullet.sv
// enemy_bullet: a single enemy projectile. Launched from (fire_x, fire_y), it falls step_p
// pixels every speed_div_p unfrozen frame ticks, pulses hit_o when its box overlaps the
// live player ship and miss_o when it drops below the last visible row.
// Optional build macro ENEMY_BULLET_HOMING_EN: on every move the bullet also drifts one
// pixel toward the player centre column. Without it the column is fixed for the flight.
module enemy_bullet #(
    parameter int unsigned step_p       = 4,
    parameter int unsigned speed_div_p  = 2,
    parameter int unsigned bullet_w_p   = 2,
    parameter int unsigned bullet_h_p   = 8,
    parameter int unsigned player_top_p = 440,
    parameter int unsigned player_bot_p = 455,
    parameter int unsigned screen_bot_p = 479,
    parameter logic [11:0] color_p      = 12'hF00
) (
    input  logic          clk_i,
    input  logic          reset_i,
    enemy_bullet_if.slave bus
);

    localparam int unsigned DivW = (speed_div_p > 1) ? $clog2(speed_div_p) : 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFlight = 2'd1,
        StHit    = 2'd2
    } state_e;

    state_e          state_q;
    logic [9:0]      x_q;
    logic [9:0]      y_q;
    logic [DivW-1:0] div_q;
    logic            hit_q;
    logic            miss_q;

    // All position arithmetic is done 11 bits wide so y+step never wraps past 1023.
    logic [10:0] fire_bot;
    logic [10:0] bullet_bot;
    logic [10:0] bullet_right;
    logic [10:0] next_y;
    logic        launch_ok;
    logic        overlap;
    logic        collide;
    logic        step;
    logic        div_wrap;
    logic [9:0]  x_move;

    assign fire_bot     = {1'b0, bus.fire_y_i} + 11'(bullet_h_p - 1);
    assign bullet_bot   = {1'b0, y_q} + 11'(bullet_h_p - 1);
    assign bullet_right = {1'b0, x_q} + 11'(bullet_w_p - 1);
    assign next_y       = {1'b0, y_q} + 11'(step_p);

    // A launch is only accepted if the whole bullet starts on screen.
    assign launch_ok = (fire_bot <= 11'(screen_bot_p));

    // Inclusive box overlap between the bullet and the player ship span.
    assign overlap = (bullet_bot >= 11'(player_top_p))
                   && ({1'b0, y_q} <= 11'(player_bot_p))
                   && (bullet_right >= {1'b0, bus.player_left_i})
                   && ({1'b0, x_q} <= {1'b0, bus.player_right_i});

    assign collide  = overlap && !bus.freeze_i && bus.player_alive_i;
    assign step     = bus.frame_tick_i && !bus.freeze_i;
    assign div_wrap = (div_q == DivW'(speed_div_p - 1));

`ifdef ENEMY_BULLET_HOMING_EN
    localparam logic [9:0] XMax = 10'(640 - bullet_w_p);

    logic [10:0] centre_sum;
    logic [9:0]  centre;

    assign centre_sum = {1'b0, bus.player_left_i} + {1'b0, bus.player_right_i};
    assign centre     = centre_sum[10:1];

    // Column after a move: one pixel toward the player centre, clamped on screen.
    always_comb begin
        x_move = x_q;
        if (x_q < centre) begin
            x_move = x_q + 10'd1;
        end else if (x_q > centre) begin
            x_move = x_q - 10'd1;
        end
        if (x_move > XMax) begin
            x_move = XMax;
        end
    end
`else
    // Column after a move: unchanged, the bullet falls straight down.
    always_comb begin
        x_move = x_q;
    end
`endif

    // Flight FSM with registered position, divider and hit/miss pulses.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            div_q   <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.fire_i && launch_ok) begin
                        x_q     <= bus.fire_x_i;
                        y_q     <= bus.fire_y_i;
                        div_q   <= '0;
                        state_q <= StFlight;
                    end
                end
                StFlight: begin
                    // Collision beats a same-cycle move so a hit is never lost to a miss.
                    if (collide) begin
                        hit_q   <= 1'b1;
                        state_q <= StHit;
                    end else if (step) begin
                        if (div_wrap) begin
                            div_q <= '0;
                            if (next_y > 11'(screen_bot_p)) begin
                                miss_q  <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                y_q <= next_y[9:0];
                                x_q <= x_move;
                            end
                        end else begin
                            div_q <= div_q + DivW'(1);
                        end
                    end
                end
                StHit: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.fire_ready_o   = (state_q == StIdle);
    assign bus.active_o       = (state_q == StFlight);
    assign bus.bullet_x_o     = x_q;
    assign bus.bullet_y_o     = y_q;
    assign bus.hit_o          = hit_q;
    assign bus.miss_o         = miss_q;
    assign bus.bullet_red_o   = color_p[11:8];
    assign bus.bullet_green_o = color_p[7:4];
    assign bus.bullet_blue_o  = color_p[3:0];
    assign bus.state_o        = state_q;

endmodule

// File: tb/tb_enemy_bullet.sv
// tb_enemy_bullet: directed table of single-cycle vectors plus hand-written flight
// sequences (hit, miss, freeze, reset mid-flight) for enemy_bullet with default parameters.
module tb_enemy_bullet;

    localparam logic [9:0] FarL  = 10'd100;
    localparam logic [9:0] FarR  = 10'd135;
    localparam logic [9:0] NearL = 10'd280;
    localparam logic [9:0] NearR = 10'd315;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    enemy_bullet_if bus();

    enemy_bullet dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       fire;
        logic [9:0] fx;
        logic [9:0] fy;
        logic       tick;
        logic       frz;
        logic       alive;
        logic [9:0] pl;
        logic [9:0] pr;
        logic [1:0] st;
        logic       rdy;
        logic       act;
        logic       hit;
        logic       miss;
        logic       cxy;
        logic [9:0] ex;
        logic [9:0] ey;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic fire, input int fx, input int fy,
                                input logic tick, input logic frz, input logic alive,
                                input logic [9:0] pl, input logic [9:0] pr,
                                input int st, input logic rdy, input logic act,
                                input logic hit, input logic miss, input logic cxy,
                                input int ex, input int ey);
        vec_t v;
        v.rst = rst; v.fire = fire; v.fx = 10'(fx); v.fy = 10'(fy);
        v.tick = tick; v.frz = frz; v.alive = alive; v.pl = pl; v.pr = pr;
        v.st = 2'(st); v.rdy = rdy; v.act = act; v.hit = hit; v.miss = miss;
        v.cxy = cxy; v.ex = 10'(ex); v.ey = 10'(ey);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs(input logic [9:0] pl, input logic [9:0] pr, input logic alive);
        bus.fire_i         = 1'b0;
        bus.fire_x_i       = '0;
        bus.fire_y_i       = '0;
        bus.frame_tick_i   = 1'b0;
        bus.freeze_i       = 1'b0;
        bus.player_alive_i = alive;
        bus.player_left_i  = pl;
        bus.player_right_i = pr;
    endtask

    task automatic launch(input int fx, input int fy, input logic [9:0] pl,
                          input logic [9:0] pr, input logic alive);
        idle_inputs(pl, pr, alive);
        bus.fire_i   = 1'b1;
        bus.fire_x_i = 10'(fx);
        bus.fire_y_i = 10'(fy);
        cyc();
        bus.fire_i = 1'b0;
        chk("launch state", bus.state_o, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    // Tick every cycle until miss_o; checks miss timing, width and that no hit fires.
    task automatic run_miss(input string tag, input logic [9:0] pl, input logic [9:0] pr,
                            input logic alive);
        int   miss_at = 0;
        int   last_y  = 0;
        logic hit_seen = 1'b0;
        launch(300, 400, pl, pr, alive);
        for (int n = 1; n <= 100; n++) begin
            bus.frame_tick_i = 1'b1;
            cyc();
            if (bus.hit_o) hit_seen = 1'b1;
            if (bus.miss_o) begin
                miss_at = n;
                break;
            end
            last_y = int'(bus.bullet_y_o);
        end
        bus.frame_tick_i = 1'b0;
        chk({tag, " miss tick"}, miss_at, 40);
        chk({tag, " last y"}, last_y, 476);
        chk({tag, " no hit"}, hit_seen, 0);
        chk({tag, " miss state"}, bus.state_o, 0);
        cyc();
        chk({tag, " miss width"}, bus.miss_o, 0);
        chk({tag, " ready after miss"}, bus.fire_ready_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst fire fx fy tick frz alive pl pr | st rdy act hit miss cxy ex ey
        vecs.push_back(mk(0, 0, 0,   0,   0, 0, 1, FarL,  FarR,  0, 1, 0, 0, 0, 1, 0,   0));
        vecs.push_back(mk(0, 1, 300, 475, 0, 0, 1, FarL,  FarR,  0, 1, 0, 0, 0, 1, 0,   0));
        vecs.push_back(mk(0, 1, 300, 473, 0, 0, 1, FarL,  FarR,  0, 1, 0, 0, 0, 1, 0,   0));
        vecs.push_back(mk(0, 1, 300, 472, 0, 0, 1, FarL,  FarR,  1, 0, 1, 0, 0, 1, 300, 472));
        vecs.push_back(mk(0, 1, 50,  10,  0, 0, 1, FarL,  FarR,  1, 0, 1, 0, 0, 1, 300, 472));
        vecs.push_back(mk(0, 0, 0,   0,   1, 0, 1, FarL,  FarR,  1, 0, 1, 0, 0, 1, 300, 472));
        vecs.push_back(mk(0, 0, 0,   0,   1, 0, 1, FarL,  FarR,  1, 0, 1, 0, 0, 1, 300, 476));
        vecs.push_back(mk(0, 0, 0,   0,   1, 0, 1, FarL,  FarR,  1, 0, 1, 0, 0, 1, 300, 476));
        vecs.push_back(mk(0, 0, 0,   0,   1, 0, 1, FarL,  FarR,  0, 1, 0, 0, 1, 0, 0,   0));
        vecs.push_back(mk(0, 0, 0,   0,   0, 0, 1, FarL,  FarR,  0, 1, 0, 0, 0, 0, 0,   0));
        vecs.push_back(mk(0, 1, 10,  0,   0, 1, 1, FarL,  FarR,  1, 0, 1, 0, 0, 1, 10,  0));
        vecs.push_back(mk(1, 1, 20,  20,  1, 0, 1, FarL,  FarR,  0, 1, 0, 0, 0, 1, 0,   0));
        vecs.push_back(mk(0, 1, 300, 440, 0, 0, 1, NearL, NearR, 1, 0, 1, 0, 0, 1, 300, 440));
        vecs.push_back(mk(0, 0, 0,   0,   0, 0, 1, NearL, NearR, 2, 0, 0, 1, 0, 0, 0,   0));
        vecs.push_back(mk(0, 0, 0,   0,   0, 0, 1, NearL, NearR, 0, 1, 0, 0, 0, 0, 0,   0));
        vecs.push_back(mk(0, 1, 278, 440, 0, 0, 1, NearL, NearR, 1, 0, 1, 0, 0, 1, 278, 440));
        vecs.push_back(mk(0, 0, 0,   0,   0, 0, 1, NearL, NearR, 1, 0, 1, 0, 0, 1, 278, 440));
        vecs.push_back(mk(1, 0, 0,   0,   0, 0, 1, NearL, NearR, 0, 1, 0, 0, 0, 1, 0,   0));
        vecs.push_back(mk(0, 1, 279, 440, 0, 0, 1, NearL, NearR, 1, 0, 1, 0, 0, 1, 279, 440));
        vecs.push_back(mk(0, 0, 0,   0,   0, 0, 1, NearL, NearR, 2, 0, 0, 1, 0, 0, 0,   0));
        vecs.push_back(mk(0, 0, 0,   0,   0, 0, 1, NearL, NearR, 0, 1, 0, 0, 0, 0, 0,   0));
        vecs.push_back(mk(0, 1, 300, 440, 0, 1, 1, NearL, NearR, 1, 0, 1, 0, 0, 1, 300, 440));
        vecs.push_back(mk(0, 0, 0,   0,   1, 1, 1, NearL, NearR, 1, 0, 1, 0, 0, 1, 300, 440));
        vecs.push_back(mk(0, 0, 0,   0,   0, 0, 1, NearL, NearR, 2, 0, 0, 1, 0, 0, 0,   0));
        vecs.push_back(mk(0, 0, 0,   0,   0, 0, 1, NearL, NearR, 0, 1, 0, 0, 0, 0, 0,   0));
        vecs.push_back(mk(0, 1, 300, 440, 0, 0, 0, NearL, NearR, 1, 0, 1, 0, 0, 1, 300, 440));
        vecs.push_back(mk(0, 0, 0,   0,   0, 0, 0, NearL, NearR, 1, 0, 1, 0, 0, 1, 300, 440));
        vecs.push_back(mk(1, 0, 0,   0,   0, 0, 1, NearL, NearR, 0, 1, 0, 0, 0, 1, 0,   0));
        vecs.push_back(mk(0, 1, 300, 456, 0, 0, 1, NearL, NearR, 1, 0, 1, 0, 0, 1, 300, 456));
        vecs.push_back(mk(0, 0, 0,   0,   0, 0, 1, NearL, NearR, 1, 0, 1, 0, 0, 1, 300, 456));
        vecs.push_back(mk(1, 0, 0,   0,   0, 0, 1, NearL, NearR, 0, 1, 0, 0, 0, 1, 0,   0));
        vecs.push_back(mk(0, 1, 300, 432, 0, 0, 1, NearL, NearR, 1, 0, 1, 0, 0, 1, 300, 432));
        vecs.push_back(mk(0, 0, 0,   0,   0, 0, 1, NearL, NearR, 1, 0, 1, 0, 0, 1, 300, 432));
        vecs.push_back(mk(1, 0, 0,   0,   0, 0, 1, NearL, NearR, 0, 1, 0, 0, 0, 1, 0,   0));
        vecs.push_back(mk(0, 1, 300, 433, 0, 0, 1, NearL, NearR, 1, 0, 1, 0, 0, 1, 300, 433));
        vecs.push_back(mk(0, 0, 0,   0,   0, 0, 1, NearL, NearR, 2, 0, 0, 1, 0, 0, 0,   0));
        vecs.push_back(mk(0, 0, 0,   0,   0, 0, 1, NearL, NearR, 0, 1, 0, 0, 0, 0, 0,   0));
        vecs.push_back(mk(0, 1, 316, 440, 0, 0, 1, NearL, NearR, 1, 0, 1, 0, 0, 1, 316, 440));
        vecs.push_back(mk(0, 0, 0,   0,   0, 0, 1, NearL, NearR, 1, 0, 1, 0, 0, 1, 316, 440));
        vecs.push_back(mk(1, 0, 0,   0,   0, 0, 1, NearL, NearR, 0, 1, 0, 0, 0, 1, 0,   0));
        vecs.push_back(mk(0, 1, 315, 440, 0, 0, 1, NearL, NearR, 1, 0, 1, 0, 0, 1, 315, 440));
        vecs.push_back(mk(0, 0, 0,   0,   0, 0, 1, NearL, NearR, 2, 0, 0, 1, 0, 0, 0,   0));
        vecs.push_back(mk(0, 0, 0,   0,   0, 0, 1, NearL, NearR, 0, 1, 0, 0, 0, 0, 0,   0));

        // Reset state
        idle_inputs(FarL, FarR, 1'b1);
        reset = 1'b1;
        cyc();
        cyc();
        chk("reset state", bus.state_o, 0);
        chk("reset ready", bus.fire_ready_o, 1);
        chk("reset active", bus.active_o, 0);
        chk("reset hit", bus.hit_o, 0);
        chk("reset miss", bus.miss_o, 0);
        chk("reset x", bus.bullet_x_o, 0);
        chk("reset y", bus.bullet_y_o, 0);
        chk("colour red", bus.bullet_red_o, 15);
        chk("colour green", bus.bullet_green_o, 0);
        chk("colour blue", bus.bullet_blue_o, 0);
        reset = 1'b0;

        // Table-driven single-cycle vectors
        foreach (vecs[i]) begin
            reset              = vecs[i].rst;
            bus.fire_i         = vecs[i].fire;
            bus.fire_x_i       = vecs[i].fx;
            bus.fire_y_i       = vecs[i].fy;
            bus.frame_tick_i   = vecs[i].tick;
            bus.freeze_i       = vecs[i].frz;
            bus.player_alive_i = vecs[i].alive;
            bus.player_left_i  = vecs[i].pl;
            bus.player_right_i = vecs[i].pr;
            cyc();
            chk($sformatf("v%0d state", i), bus.state_o, vecs[i].st);
            chk($sformatf("v%0d ready", i), bus.fire_ready_o, vecs[i].rdy);
            chk($sformatf("v%0d active", i), bus.active_o, vecs[i].act);
            chk($sformatf("v%0d hit", i), bus.hit_o, vecs[i].hit);
            chk($sformatf("v%0d miss", i), bus.miss_o, vecs[i].miss);
            if (vecs[i].cxy) begin
                chk($sformatf("v%0d x", i), bus.bullet_x_o, vecs[i].ex);
                chk($sformatf("v%0d y", i), bus.bullet_y_o, vecs[i].ey);
            end
        end
        reset = 1'b0;
        do_reset();

        // Fall onto the player with a tick every 4 clocks: 18 ticks reach y=436, then hit.
        launch(300, 400, NearL, NearR, 1'b1);
        for (int t = 1; t <= 18; t++) begin
            bus.frame_tick_i = 1'b1;
            cyc();
            bus.frame_tick_i = 1'b0;
            chk($sformatf("fall y t%0d", t), bus.bullet_y_o, 400 + 4 * (t / 2));
            chk($sformatf("fall hit t%0d", t), bus.hit_o, 0);
            if (t < 18) begin
                cyc();
                cyc();
                cyc();
            end
        end
        chk("fall pre-hit state", bus.state_o, 1);
        cyc();
        chk("fall hit pulse", bus.hit_o, 1);
        chk("fall hit state", bus.state_o, 2);
        chk("fall hit active", bus.active_o, 0);
        chk("fall hit no miss", bus.miss_o, 0);
        cyc();
        chk("fall hit width", bus.hit_o, 0);
        chk("fall back idle", bus.state_o, 0);

        // Misses: player elsewhere, and player overlapping but dead.
        run_miss("far", FarL, FarR, 1'b1);
        run_miss("dead", NearL, NearR, 1'b0);

        // Freeze mid-flight holds y and divider, then reset mid-flight.
        launch(300, 400, FarL, FarR, 1'b1);
        for (int t = 1; t <= 7; t++) begin
            bus.frame_tick_i = 1'b1;
            cyc();
        end
        chk("pre-freeze y", bus.bullet_y_o, 412);
        bus.freeze_i = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            cyc();
            chk($sformatf("frozen y t%0d", t), bus.bullet_y_o, 412);
        end
        chk("frozen state", bus.state_o, 1);
        bus.freeze_i = 1'b0;
        cyc();
        chk("resume y", bus.bullet_y_o, 416);
        cyc();
        cyc();
        chk("pre-reset y", bus.bullet_y_o, 420);
        reset      = 1'b1;
        bus.fire_i = 1'b1;
        cyc();
        reset      = 1'b0;
        bus.fire_i = 1'b0;
        bus.frame_tick_i = 1'b0;
        chk("midflight reset state", bus.state_o, 0);
        chk("midflight reset active", bus.active_o, 0);
        chk("midflight reset ready", bus.fire_ready_o, 1);
        chk("midflight reset hit", bus.hit_o, 0);
        chk("midflight reset miss", bus.miss_o, 0);
        chk("midflight reset y", bus.bullet_y_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
